dp_ram_pipe: RTL

Parametrised simple dual-port RAM (1 write port, 1 read port) and the next generation of the team's 8-bit 1R/1W byte RAM.
- Adds generic data width and depth.
- Adds per-byte write enables.
- Adds selectable read latency (1 or 2) with a read-valid strobe.
- Adds a selectable read-during-write policy, plus collision flagging and counting.
- Intended as the buffer primitive under packet FIFOs and scratchpads. One read and one write may be issued every cycle.

---
 rtl/dp_ram_pkg.sv | 22 ++
 rtl/dp_ram_rd_pipe.sv | 80 ++++++++
 rtl/dp_ram_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dp_ram_pipe simple dual-port RAM.
package dp_ram_pkg;

   typedef enum logic {
      RDW_OLD = 1'b0,
      RDW_NEW = 1'b1
   } rdw_mode_e;

   localparam int BYTE_W     = 8;
   localparam int MAX_DATA_W = 1024;
   localparam int MAX_NB     = MAX_DATA_W / BYTE_W;

   // Even-parity bit per byte; callers zero-extend narrower words and use the low bits.
   function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DATA_W-1:0] word);
      logic [MAX_NB-1:0] par;
      for (int i = 0; i < MAX_NB; i++) begin
         par[i] = ^word[i*BYTE_W +: BYTE_W];
      end
      return par;
   endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-output pipeline for dp_ram_pipe: one or two register stages, flushed by rst.
module dp_ram_rd_pipe
   import dp_ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_coll,
   input  logic [DATA_W/BYTE_W-1:0] in_perr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     collision,
   output logic [DATA_W/BYTE_W-1:0] rd_perr
);

   localparam int NB = DATA_W / BYTE_W;

   logic              s1_valid_r;
   logic [DATA_W-1:0] s1_data_r;
   logic              s1_coll_r;
   logic [NB-1:0]     s1_perr_r;

   // First stage: data only loads on a read so it holds between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {DATA_W{1'b0}};
         s1_coll_r  <= 1'b0;
         s1_perr_r  <= {NB{1'b0}};
      end else begin
         s1_valid_r <= in_valid;
         s1_coll_r  <= in_valid & in_coll;
         s1_perr_r  <= in_valid ? in_perr : {NB{1'b0}};
         if (in_valid) begin
            s1_data_r <= in_data;
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_valid_r;
         logic [DATA_W-1:0] s2_data_r;
         logic              s2_coll_r;
         logic [NB-1:0]     s2_perr_r;

         // Second stage for the two-cycle latency build
         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid_r <= 1'b0;
               s2_data_r  <= {DATA_W{1'b0}};
               s2_coll_r  <= 1'b0;
               s2_perr_r  <= {NB{1'b0}};
            end else begin
               s2_valid_r <= s1_valid_r;
               s2_coll_r  <= s1_valid_r & s1_coll_r;
               s2_perr_r  <= s1_valid_r ? s1_perr_r : {NB{1'b0}};
               if (s1_valid_r) begin
                  s2_data_r <= s1_data_r;
               end
            end
         end

         assign rd_data   = s2_data_r;
         assign rd_valid  = s2_valid_r;
         assign collision = s2_coll_r;
         assign rd_perr   = s2_perr_r;
      end else begin : g_lat1
         assign rd_data   = s1_data_r;
         assign rd_valid  = s1_valid_r;
         assign collision = s1_coll_r;
         assign rd_perr   = s1_perr_r;
      end
   endgenerate

endmodule

// File: rtl/dp_ram_pipe.sv
// Parametrised 1W/1R RAM with byte enables, RD_LAT 1/2 and RDW policy.
// Define DP_RAM_PARITY_EN to store and check one even-parity bit per byte.
module dp_ram_pipe
   import dp_ram_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W/BYTE_W-1:0] wr_be,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     collision,
   output logic [15:0]              collision_cnt,
   output logic [DATA_W/BYTE_W-1:0] rd_perr
);

   localparam int        NB    = DATA_W / BYTE_W;
   localparam int        DEPTH = 2 ** ADDR_W;
   localparam rdw_mode_e MODE  = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic              rd_go_s;
   logic              collide_s;
   logic [DATA_W-1:0] rd_word_s;
   logic [NB-1:0]     rd_perr_s;
   logic [15:0]       coll_cnt_r;

   assign rd_go_s   = rd_en & ~rst;
   assign collide_s = rd_go_s & wr_en & (rd_addr == wr_addr) & (|wr_be);

   // Byte-masked array write; the array itself is never reset
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               mem_r[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Read word, with enabled write bytes forwarded in the NEW policy
   always_comb begin
      rd_word_s = mem_r[rd_addr];
      for (int i = 0; i < NB; i++) begin
         if ((MODE == RDW_NEW) && collide_s && wr_be[i]) begin
            rd_word_s[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
         end else begin
            rd_word_s[i*BYTE_W +: BYTE_W] = mem_r[rd_addr][i*BYTE_W +: BYTE_W];
         end
      end
   end

`ifdef DP_RAM_PARITY_EN
   logic [NB-1:0]         par_r [DEPTH];
   logic [MAX_DATA_W-1:0] wr_wide_s;
   logic [MAX_DATA_W-1:0] rd_wide_s;
   logic [MAX_NB-1:0]     wr_par_s;
   logic [MAX_NB-1:0]     rd_par_s;

   assign wr_wide_s = {{(MAX_DATA_W-DATA_W){1'b0}}, wr_data};
   assign rd_wide_s = {{(MAX_DATA_W-DATA_W){1'b0}}, mem_r[rd_addr]};
   assign wr_par_s  = byte_parity(wr_wide_s);
   assign rd_par_s  = byte_parity(rd_wide_s);

   // Parity bits follow their byte under the same enables
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               par_r[wr_addr][i] <= wr_par_s[i];
            end
         end
      end
   end

   // Forwarded bytes carry fresh parity and therefore never flag
   always_comb begin
      rd_perr_s = {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
         if ((MODE == RDW_NEW) && collide_s && wr_be[i]) begin
            rd_perr_s[i] = 1'b0;
         end else begin
            rd_perr_s[i] = rd_par_s[i] ^ par_r[rd_addr][i];
         end
      end
   end
`else
   assign rd_perr_s = {NB{1'b0}};
`endif

   // Saturating collision counter
   always_ff @(posedge clk) begin
      if (rst) begin
         coll_cnt_r <= 16'h0000;
      end else if (collide_s && (coll_cnt_r != 16'hFFFF)) begin
         coll_cnt_r <= coll_cnt_r + 16'h0001;
      end
   end

   assign collision_cnt = coll_cnt_r;

   dp_ram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_go_s),
      .in_data   (rd_word_s),
      .in_coll   (collide_s),
      .in_perr   (rd_perr_s),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .collision (collision),
      .rd_perr   (rd_perr)
   );

endmodule
